// File: rtl/multichannel_phase_accumulator.sv
// multichannel_phase_accumulator
//   Time-multiplexed NUM_CH-channel phase accumulator for the NCO/DDS path.
//   Each accepted step advances the channel selected by a round-robin
//   pointer. It emits one tagged, truncated phase sample through a
//   one-deep registered valid/ready output stage.
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   i_cfg_valid   config write strobe (always accepted)
//   i_cfg_ch      target channel for the config write
//   i_cfg_inc     new frequency word
//   i_cfg_offset  new phase offset
//   i_cfg_clr     with i_cfg_valid, also zero that channel's accumulator
//   i_in_valid    step request
//   o_in_ready    step accepted when i_in_valid && o_in_ready
//   o_out_valid   sample valid
//   i_out_ready   downstream accept
//   o_out_ch      channel tag of the held sample
//   o_out_phase   phase sample (MSBs of accumulator + offset)
//   o_out_wrap    accumulator wrapped on the step that produced this sample
module multichannel_phase_accumulator #(
  parameter int PHASE_WIDTH = 32,
  parameter int OUT_WIDTH   = 16,
  parameter int NUM_CH      = 4,
  localparam int CH_W       = $clog2(NUM_CH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_cfg_valid,
  input  logic [CH_W-1:0]        i_cfg_ch,
  input  logic [PHASE_WIDTH-1:0] i_cfg_inc,
  input  logic [PHASE_WIDTH-1:0] i_cfg_offset,
  input  logic                   i_cfg_clr,
  input  logic                   i_in_valid,
  output logic                   o_in_ready,
  output logic                   o_out_valid,
  input  logic                   i_out_ready,
  output logic [CH_W-1:0]        o_out_ch,
  output logic [OUT_WIDTH-1:0]   o_out_phase,
  output logic                   o_out_wrap
);

  logic [PHASE_WIDTH-1:0] r_acc [NUM_CH];
  logic [PHASE_WIDTH-1:0] r_inc [NUM_CH];
  logic [PHASE_WIDTH-1:0] r_off [NUM_CH];
  logic [CH_W-1:0]        r_ch_ptr;

  logic                   r_out_valid;
  logic [CH_W-1:0]        r_out_ch;
  logic [OUT_WIDTH-1:0]   r_out_phase;
  logic                   r_out_wrap;

  logic                   w_step;
  logic [PHASE_WIDTH:0]   w_sum;
  logic [PHASE_WIDTH-1:0] w_phase;
  logic [CH_W-1:0]        w_ptr_next;
  logic [NUM_CH-1:0]      w_cfg_sel;

  // One-deep output stage: a new sample may enter whenever the held one
  // is empty or is being consumed this cycle.
  assign o_in_ready = !r_out_valid || i_out_ready;
  assign w_step     = i_in_valid && o_in_ready;

  // Step always uses the pre-write inc/off, even on a same-cycle config.
  assign w_sum      = {1'b0, r_acc[r_ch_ptr]} + {1'b0, r_inc[r_ch_ptr]};
  assign w_phase    = w_sum[PHASE_WIDTH-1:0] + r_off[r_ch_ptr];
  assign w_ptr_next = (r_ch_ptr == CH_W'(NUM_CH - 1)) ? '0 : r_ch_ptr + CH_W'(1);

  // Decoding per channel silently drops writes to channels >= NUM_CH.
  always_comb begin
    w_cfg_sel = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (i_cfg_valid && (i_cfg_ch == CH_W'(c))) begin
        w_cfg_sel[c] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_acc[c] <= '0;
        r_inc[c] <= '0;
        r_off[c] <= '0;
      end
      r_ch_ptr    <= '0;
      r_out_valid <= 1'b0;
      r_out_ch    <= '0;
      r_out_phase <= '0;
      r_out_wrap  <= 1'b0;
    end else begin
      if (w_step) begin
        r_ch_ptr    <= w_ptr_next;
        r_out_valid <= 1'b1;
        r_out_ch    <= r_ch_ptr;
        // Shift instead of part-select so the low, discarded bits still count as used.
        r_out_phase <= OUT_WIDTH'(w_phase >> (PHASE_WIDTH - OUT_WIDTH));
        r_out_wrap  <= w_sum[PHASE_WIDTH];
      end else if (i_out_ready) begin
        r_out_valid <= 1'b0;
      end

      for (int c = 0; c < NUM_CH; c++) begin
        if (w_cfg_sel[c]) begin
          r_inc[c] <= i_cfg_inc;
          r_off[c] <= i_cfg_offset;
        end
        // Clear beats a same-cycle step on the same channel.
        if (w_cfg_sel[c] && i_cfg_clr) begin
          r_acc[c] <= '0;
        end else if (w_step && (r_ch_ptr == CH_W'(c))) begin
          r_acc[c] <= w_sum[PHASE_WIDTH-1:0];
        end
      end
    end
  end

  assign o_out_valid = r_out_valid;
  assign o_out_ch    = r_out_ch;
  assign o_out_phase = r_out_phase;
  assign o_out_wrap  = r_out_wrap;

endmodule

// File: tb/tb_multichannel_phase_accumulator.sv
module tb_multichannel_phase_accumulator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_cfg_valid;
  logic [1:0] i_cfg_ch;
  logic [7:0] i_cfg_inc;
  logic [7:0] i_cfg_offset;
  logic       i_cfg_clr;
  logic       i_in_valid;
  logic       o_in_ready;
  logic       o_out_valid;
  logic       i_out_ready;
  logic [1:0] o_out_ch;
  logic [7:0] o_out_phase;
  logic       o_out_wrap;

  multichannel_phase_accumulator #(
    .PHASE_WIDTH(8),
    .OUT_WIDTH  (8),
    .NUM_CH     (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_cfg_valid (i_cfg_valid),
    .i_cfg_ch    (i_cfg_ch),
    .i_cfg_inc   (i_cfg_inc),
    .i_cfg_offset(i_cfg_offset),
    .i_cfg_clr   (i_cfg_clr),
    .i_in_valid  (i_in_valid),
    .o_in_ready  (o_in_ready),
    .o_out_valid (o_out_valid),
    .i_out_ready (i_out_ready),
    .o_out_ch    (o_out_ch),
    .o_out_phase (o_out_phase),
    .o_out_wrap  (o_out_wrap)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] ch;
    logic [7:0] ph;
    logic       wr;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a transfer happens at the next posedge whenever valid && ready
  // are seen here, so each sample is checked exactly once.
  always @(negedge clk) begin
    if (rst_n && o_out_valid && i_out_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_sample: got ch %0d phase %0h, expected no sample", o_out_ch, o_out_phase);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("out_ch", 32'(o_out_ch), 32'(e.ch));
        chk("out_phase", 32'(o_out_phase), 32'(e.ph));
        chk("out_wrap", 32'(o_out_wrap), 32'(e.wr));
      end
    end
  end

  // All drivers start #1 after a posedge and end #1 after a posedge.
  task automatic step(input logic [1:0] ch, input logic [7:0] ph, input logic wr);
    exp_t e;
    i_in_valid  = 1'b1;
    i_out_ready = 1'b1;
    @(negedge clk);
    if (o_in_ready) begin
      e.ch = ch; e.ph = ph; e.wr = wr;
      exp_q.push_back(e);
    end else begin
      n_tests++;
      n_fail++;
      $display("FAIL step_ready: got in_ready 0 expected 1 for ch %0d", ch);
    end
    @(posedge clk); #1;
    i_in_valid = 1'b0;
  endtask

  task automatic cfg(input logic [1:0] ch, input logic [7:0] inc, input logic [7:0] off, input logic clr);
    i_cfg_valid  = 1'b1;
    i_cfg_ch     = ch;
    i_cfg_inc    = inc;
    i_cfg_offset = off;
    i_cfg_clr    = clr;
    @(posedge clk); #1;
    i_cfg_valid = 1'b0;
    i_cfg_clr   = 1'b0;
  endtask

  task automatic idle(input int n);
    i_in_valid  = 1'b0;
    i_out_ready = 1'b1;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got still running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n        = 1'b0;
    i_cfg_valid  = 1'b0;
    i_cfg_ch     = '0;
    i_cfg_inc    = '0;
    i_cfg_offset = '0;
    i_cfg_clr    = 1'b0;
    i_in_valid   = 1'b0;
    i_out_ready  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(o_out_valid), 0);
    chk("rst_in_ready", 32'(o_in_ready), 1);
    chk("rst_out_ch", 32'(o_out_ch), 0);
    chk("rst_out_phase", 32'(o_out_phase), 0);
    chk("rst_out_wrap", 32'(o_out_wrap), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic round robin, inc 1..4
    cfg(2'd0, 8'd1, 8'd0, 1'b0);
    cfg(2'd1, 8'd2, 8'd0, 1'b0);
    cfg(2'd2, 8'd3, 8'd0, 1'b0);
    cfg(2'd3, 8'd4, 8'd0, 1'b0);
    step(0, 8'h01, 0); step(1, 8'h02, 0); step(2, 8'h03, 0); step(3, 8'h04, 0);
    step(0, 8'h02, 0); step(1, 8'h04, 0); step(2, 8'h06, 0); step(3, 8'h08, 0);

    // Half-scale increment on ch0: wrap flagged only on the wrapping step
    cfg(2'd0, 8'h80, 8'd0, 1'b1);
    step(0, 8'h80, 0); step(1, 8'h06, 0); step(2, 8'h09, 0); step(3, 8'h0C, 0);
    step(0, 8'h00, 1); step(1, 8'h08, 0); step(2, 8'h0C, 0); step(3, 8'h10, 0);
    step(0, 8'h80, 0); step(1, 8'h0A, 0); step(2, 8'h0F, 0); step(3, 8'h14, 0);

    // Offset on ch1 is added to the output but never accumulated
    cfg(2'd1, 8'h10, 8'h40, 1'b1);
    step(0, 8'h00, 1); step(1, 8'h50, 0); step(2, 8'h12, 0); step(3, 8'h18, 0);
    step(0, 8'h80, 0); step(1, 8'h60, 0); step(2, 8'h15, 0); step(3, 8'h1C, 0);

    // Backpressure: hold ch0 sample 5 cycles, config write lands meanwhile
    step(0, 8'h00, 1);
    i_in_valid   = 1'b1;
    i_out_ready  = 1'b0;
    i_cfg_valid  = 1'b1;
    i_cfg_ch     = 2'd3;
    i_cfg_inc    = 8'd5;
    i_cfg_offset = 8'd0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_in_ready", 32'(o_in_ready), 0);
      chk("stall_out_valid", 32'(o_out_valid), 1);
      chk("stall_out_ch", 32'(o_out_ch), 0);
      chk("stall_out_phase", 32'(o_out_phase), 32'h00);
      chk("stall_out_wrap", 32'(o_out_wrap), 1);
      @(posedge clk); #1;
      i_cfg_valid = 1'b0;
    end
    step(1, 8'h70, 0); step(2, 8'h18, 0); step(3, 8'h21, 0);

    // Same-cycle clear and step on ch2
    cfg(2'd2, 8'h30, 8'd0, 1'b1);
    step(0, 8'h80, 0); step(1, 8'h80, 0); step(2, 8'h30, 0); step(3, 8'h26, 0);
    cfg(2'd2, 8'h03, 8'd0, 1'b0);
    step(0, 8'h00, 1); step(1, 8'h90, 0);
    i_cfg_valid  = 1'b1;
    i_cfg_ch     = 2'd2;
    i_cfg_inc    = 8'h07;
    i_cfg_offset = 8'd0;
    i_cfg_clr    = 1'b1;
    step(2, 8'h33, 0);
    i_cfg_valid = 1'b0;
    i_cfg_clr   = 1'b0;
    step(3, 8'h2B, 0);
    step(0, 8'h80, 0); step(1, 8'hA0, 0); step(2, 8'h07, 0); step(3, 8'h30, 0);
    idle(2);

    // Reset mid-stream with a held sample
    i_in_valid  = 1'b1;
    i_out_ready = 1'b0;
    @(posedge clk); #1;
    i_in_valid = 1'b0;
    chk("pre_rst_out_valid", 32'(o_out_valid), 1);
    chk("pre_rst_out_wrap", 32'(o_out_wrap), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", 32'(o_out_valid), 0);
    chk("async_rst_in_ready", 32'(o_in_ready), 1);
    chk("async_rst_out_wrap", 32'(o_out_wrap), 0);
    @(posedge clk); #1;
    rst_n       = 1'b1;
    i_out_ready = 1'b1;
    @(posedge clk); #1;

    // After reset: ch0 first, inc 0 gives constant phase, then full-scale wrap
    step(0, 8'h00, 0); step(1, 8'h00, 0); step(2, 8'h00, 0); step(3, 8'h00, 0);
    cfg(2'd0, 8'hFF, 8'd0, 1'b0);
    step(0, 8'hFF, 0); step(1, 8'h00, 0); step(2, 8'h00, 0); step(3, 8'h00, 0);
    step(0, 8'hFE, 1);
    idle(3);

    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
